// File: rtl/nms_stage_if.sv
// rtl/nms_stage_if.sv - pixel in/out handshake bundle for the non-maximum suppression stage
interface nms_stage_if;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_mag;
  logic [1:0] i_dir;
  logic       o_valid;
  logic [7:0] o_pixel;
  logic       o_eof;

  modport master (
    output i_valid, i_mag, i_dir,
    input  i_ready, o_valid, o_pixel, o_eof
  );

  modport slave (
    input  i_valid, i_mag, i_dir,
    output i_ready, o_valid, o_pixel, o_eof
  );
endinterface

// File: rtl/nms_stage.sv
// rtl/nms_stage.sv - 3x3 non-maximum suppression over a raster stream of {dir,mag} pixels
// Two line buffers plus a 3x3 window; output for centre k-W-1 is registered on acceptance of k.
module nms_stage #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic      i_clk,
  input logic      i_rst_n,
  nms_stage_if.slave bus
);
  localparam int W  = IMG_WIDTH;
  localparam int H  = IMG_HEIGHT;
  localparam int N  = W * H;
  localparam int KW = $clog2(N);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int FW = $clog2(W + 1);

  localparam logic [KW-1:0] K_FILL_END = KW'(W);
  localparam logic [KW-1:0] K_LAST     = KW'(N - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(H - 1);
  localparam logic [FW-1:0] FL_LAST    = FW'(W);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] kc_q, kc_d;
  logic [RW-1:0] pr_q, pr_d;
  logic [CW-1:0] pc_q, pc_d;
  logic [FW-1:0] fl_q, fl_d;
  logic          o_valid_q, o_valid_d;
  logic [7:0]    o_pixel_q, o_pixel_d;
  logic          o_eof_q, o_eof_d;
  logic [9:0]    win_q [3][3];
  logic [9:0]    win_d [3][3];

  logic [9:0]    lb1 [W];
  logic [9:0]    lb2 [W];

  logic          accept;
  logic [9:0]    nw [3][3];
  logic [9:0]    nb_a, nb_b;
  logic [7:0]    nms_val;
  logic          border;
  logic          emit;

  assign accept       = bus.i_valid && (state_q != FLUSH);
  assign bus.i_ready  = (state_q != FLUSH);
  assign bus.o_valid  = o_valid_q;
  assign bus.o_pixel  = o_pixel_q;
  assign bus.o_eof    = o_eof_q;

  // Window after this cycle's shift: right column is rows k-2W, k-W, k
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = win_q[r][1];
      nw[r][1] = win_q[r][2];
    end
    nw[0][2] = lb2[kc_q];
    nw[1][2] = lb1[kc_q];
    nw[2][2] = {bus.i_dir, bus.i_mag};
  end

  always_comb begin
    nb_a = nw[1][0];
    nb_b = nw[1][2];
    case (nw[1][1][9:8])
      2'd1: begin nb_a = nw[0][2]; nb_b = nw[2][0]; end
      2'd2: begin nb_a = nw[0][1]; nb_b = nw[2][1]; end
      2'd3: begin nb_a = nw[0][0]; nb_b = nw[2][2]; end
      default: begin nb_a = nw[1][0]; nb_b = nw[1][2]; end
    endcase
    nms_val = ((nw[1][1][7:0] >= nb_a[7:0]) && (nw[1][1][7:0] >= nb_b[7:0]))
              ? nw[1][1][7:0] : 8'd0;
    border  = (pr_q == '0) || (pr_q == ROW_LAST) || (pc_q == '0) || (pc_q == COL_LAST);
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    kc_d      = kc_q;
    pr_d      = pr_q;
    pc_d      = pc_q;
    fl_d      = fl_q;
    win_d     = win_q;
    o_valid_d = 1'b0;
    o_pixel_d = 8'd0;
    o_eof_d   = 1'b0;
    emit      = 1'b0;

    if (accept) begin
      win_d = nw;
      k_d   = k_q + 1'b1;
      kc_d  = (kc_q == COL_LAST) ? '0 : kc_q + 1'b1;
    end

    case (state_q)
      FILL: begin
        if (accept && (k_q == K_FILL_END)) state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          emit      = 1'b1;
          o_valid_d = 1'b1;
          o_pixel_d = border ? 8'd0 : nms_val;
          if (k_q == K_LAST) begin
            state_d = FLUSH;
            k_d     = '0;
          end
        end
      end
      FLUSH: begin
        // Remaining last-row centres are all border, so no more input is needed
        emit      = 1'b1;
        o_valid_d = 1'b1;
        fl_d      = fl_q + 1'b1;
        if (fl_q == FL_LAST) begin
          o_eof_d = 1'b1;
          fl_d    = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (emit) begin
      if (pc_q == COL_LAST) begin
        pc_d = '0;
        pr_d = (pr_q == ROW_LAST) ? '0 : pr_q + 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FILL;
      k_q       <= '0;
      kc_q      <= '0;
      pr_q      <= '0;
      pc_q      <= '0;
      fl_q      <= '0;
      o_valid_q <= 1'b0;
      o_pixel_q <= 8'd0;
      o_eof_q   <= 1'b0;
      win_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      kc_q      <= kc_d;
      pr_q      <= pr_d;
      pc_q      <= pc_d;
      fl_q      <= fl_d;
      o_valid_q <= o_valid_d;
      o_pixel_q <= o_pixel_d;
      o_eof_q   <= o_eof_d;
      win_q     <= win_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb2[kc_q] <= lb1[kc_q];
      lb1[kc_q] <= {bus.i_dir, bus.i_mag};
    end
  end
endmodule

// File: doc/nms_stage.md
NMS_STAGE -- requirements
Module: nms_stage

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per row (W, ≥4).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, rows per frame (H, ≥3); N = W*H.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  input pixel present this cycle.
REQ-006 SHALL have port i_ready  output  1  block accepts input this cycle; transfer = i_valid & i_ready.
REQ-007 SHALL have port i_mag  input  8  gradient magnitude, unsigned, raster order.
REQ-008 SHALL have port i_dir  input  2  quantized gradient direction: 0=0°, 1=45°, 2=90°, 3=135°.
REQ-009 SHALL have port o_valid  output  1  o_pixel valid this cycle; no backpressure (downstream threshold stage always accepts).
REQ-010 SHALL have port o_pixel  output  8  suppressed magnitude, raster order.
REQ-011 SHALL have port o_eof  output  1  high with the last output pixel (index N-1) of a frame.

Function
REQ-012 SHALL store two previous rows of {mag,dir} in line buffers of depth W (10-bit entries) plus a 3x3 window register; buffers need no clearing.
REQ-013 SHALL keep a linear input index k (0..N-1) and row/column counters of the window centre; k wraps to 0 after N-1.
REQ-014 SHALL implement states FILL, RUN, FLUSH.
REQ-015 FILL: i_ready=1, o_valid=0; transition to RUN when index k=W is accepted.
REQ-016 RUN: i_ready=1; accepting index k SHALL produce output index p=k-W-1 exactly one cycle later (o_valid=1 that cycle only); no accept -> o_valid=0 next cycle.
REQ-017 RUN -> FLUSH on acceptance of k=N-1.
REQ-018 FLUSH: i_ready=0; outputs p=N-W-1..N-1 (all border, value 0) SHALL be emitted on W+1 consecutive cycles directly following the output for p=N-W-2; o_eof=1 with p=N-1; next cycle state=FILL, k=0, i_ready=1.
REQ-019 Border: centre in row 0, row H-1, column 0 or column W-1 SHALL output 0 regardless of window contents (wrap-around neighbours ignored).
REQ-020 Interior: neighbours chosen by centre dir: 0 -> left/right; 1 -> up-right/down-left; 2 -> up/down; 3 -> up-left/down-right.
REQ-021 Interior: o_pixel = centre mag if centre mag ≥ both neighbours (unsigned 8-bit compare, ties kept), else 0.
REQ-022 Output stream SHALL contain exactly N pixels per frame, one per input pixel, in raster order.
REQ-023 i_valid gaps SHALL stall the pipeline without loss or duplication; i_mag/i_dir ignored when no transfer.
REQ-024 When i_ready=0, i_valid SHALL be ignored (no accept).

Reset
REQ-025 i_rst_n low SHALL immediately force state=FILL, k=0, counters=0, o_valid=0, o_pixel=0, o_eof=0, i_ready=1 (i_ready held 1 during reset).
REQ-026 Reset mid-frame SHALL abandon the partial frame; first transfer after release is pixel (0,0) of a new frame.
REQ-027 Line-buffer and window contents SHALL NOT affect outputs after reset (first-row reads are border by REQ-019).

Verification (W=4, H=4, N=16)
REQ-028 Flat frame, all mag=50, dir=0, i_valid continuous -> 16 outputs; interior (1,1),(1,2),(2,1),(2,2)=50, others 0; first o_valid one cycle after k=5 accepted; o_eof on 16th output.
REQ-029 Ridge: column 1 mag=200, others 10, dir=0 -> (1,1),(2,1)=200; (1,2),(2,2)=0; dir=2 on same data -> (1,1),(2,1),(1,2),(2,2) = 200,200,10,10.
REQ-030 Diagonal dir=1, centre (1,1)=80, up-right (0,2)=80, down-left (2,0)=79 -> (1,1)=80 (tie kept); set (0,2)=81 -> (1,1)=0.
REQ-031 Random i_valid (50% duty) on REQ-028 frame -> identical output sequence; i_ready=0 for exactly 5 FLUSH cycles; back-to-back second frame correct.
REQ-032 Assert i_rst_n low after 9 pixels accepted, release, send full frame -> o_valid=0 during reset, 16 correct outputs, no residue from aborted frame.
